// File: rtl/hqb_matmul_cal.sv
// Complex fixed-point matrix multiply Y = H*B, one complex MAC per cycle.
// Latency: last element written NR*NC*K edges after the accepting edge; done pulses the cycle after.
// Backpressure: none; start is only sampled in IDLE, requests while busy are dropped.
module hqb_matmul_cal #(
    parameter int W    = 16,
    parameter int FRAC = 8,
    parameter int NR   = 4,
    parameter int K    = 2,
    parameter int NC   = 2,
    parameter int SAT  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NR*K*W-1:0]    h_r,
    input  logic [NR*K*W-1:0]    h_i,
    input  logic [K*NC*W-1:0]    b_r,
    input  logic [K*NC*W-1:0]    b_i,
    output logic [NR*NC*W-1:0]   y_r,
    output logic [NR*NC*W-1:0]   y_i,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf
);

    // Accumulator carries the full sum of K complex products without overflow.
    localparam int AW = 2*W + 1 + $clog2(K);
    localparam int RW = (NR > 1) ? $clog2(NR) : 1;
    localparam int KW = (K  > 1) ? $clog2(K)  : 1;
    localparam int CW = (NC > 1) ? $clog2(NC) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [NR*K*W-1:0]    r_h_r, r_h_i;
    logic [K*NC*W-1:0]    r_b_r, r_b_i;
    logic [RW-1:0]        r_row;
    logic [KW-1:0]        r_k;
    logic [CW-1:0]        r_col;
    logic signed [AW-1:0] r_acc_r, r_acc_i;
    logic [W-1:0]         r_y_r [NC][NR];
    logic [W-1:0]         r_y_i [NC][NR];
    logic                 r_busy, r_done, r_ovf;

    logic [W-1:0]         w_h_r_a [NR][K];
    logic [W-1:0]         w_h_i_a [NR][K];
    logic [W-1:0]         w_b_r_a [K][NC];
    logic [W-1:0]         w_b_i_a [K][NC];
    logic [2*W-1:0]       w_hr_x, w_hi_x, w_br_x, w_bi_x;
    logic [2*W-1:0]       w_p_rr, w_p_ii, w_p_ri, w_p_ir;
    logic signed [AW-1:0] w_mac_r, w_mac_i;
    logic signed [AW-1:0] w_sh_r, w_sh_i;
    logic                 w_oor_r, w_oor_i;
    logic [W-1:0]         w_res_r, w_res_i;

    // True when a shifted value does not fit the signed W-bit range.
    function automatic logic out_of_range(input logic [AW-1:0] v);
        logic [AW-W:0] top;
        top = v[AW-1:W-1];
        return !((&top) || !(|top));
    endfunction

    // Reduce a shifted value to W bits, clamping or wrapping.
    function automatic logic [W-1:0] reduce(input logic [AW-1:0] v);
        logic [W-1:0] res;
        res = v[W-1:0];
        if (SAT != 0 && out_of_range(v)) begin
            res = v[AW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
        return res;
    endfunction

    // Unpack the captured operand vectors into element arrays.
    always_comb begin
        for (int r = 0; r < NR; r++) begin
            for (int k = 0; k < K; k++) begin
                w_h_r_a[r][k] = r_h_r[(r*K+k)*W +: W];
                w_h_i_a[r][k] = r_h_i[(r*K+k)*W +: W];
            end
        end
        for (int k = 0; k < K; k++) begin
            for (int c = 0; c < NC; c++) begin
                w_b_r_a[k][c] = r_b_r[(k*NC+c)*W +: W];
                w_b_i_a[k][c] = r_b_i[(k*NC+c)*W +: W];
            end
        end
    end

    // One complex MAC on the current (r,k,c) operands, then shift and reduce.
    always_comb begin
        w_hr_x  = {{W{w_h_r_a[r_row][r_k][W-1]}}, w_h_r_a[r_row][r_k]};
        w_hi_x  = {{W{w_h_i_a[r_row][r_k][W-1]}}, w_h_i_a[r_row][r_k]};
        w_br_x  = {{W{w_b_r_a[r_k][r_col][W-1]}}, w_b_r_a[r_k][r_col]};
        w_bi_x  = {{W{w_b_i_a[r_k][r_col][W-1]}}, w_b_i_a[r_k][r_col]};
        w_p_rr  = w_hr_x * w_br_x;
        w_p_ii  = w_hi_x * w_bi_x;
        w_p_ri  = w_hr_x * w_bi_x;
        w_p_ir  = w_hi_x * w_br_x;
        w_mac_r = r_acc_r + {{(AW-2*W){w_p_rr[2*W-1]}}, w_p_rr}
                          - {{(AW-2*W){w_p_ii[2*W-1]}}, w_p_ii};
        w_mac_i = r_acc_i + {{(AW-2*W){w_p_ri[2*W-1]}}, w_p_ri}
                          + {{(AW-2*W){w_p_ir[2*W-1]}}, w_p_ir};
        w_sh_r  = w_mac_r >>> FRAC;
        w_sh_i  = w_mac_i >>> FRAC;
        w_oor_r = out_of_range(w_sh_r);
        w_oor_i = out_of_range(w_sh_i);
        w_res_r = reduce(w_sh_r);
        w_res_i = reduce(w_sh_i);
    end

    // Pack the result registers into the column-major output vectors.
    always_comb begin
        y_r = '0;
        y_i = '0;
        for (int c = 0; c < NC; c++) begin
            for (int r = 0; r < NR; r++) begin
                y_r[(c*NR+r)*W +: W] = r_y_r[c][r];
                y_i[(c*NR+r)*W +: W] = r_y_i[c][r];
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign ovf  = r_ovf;

    // Control FSM, index sequencing (k innermost, then r, then c) and result write-back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_h_r   <= '0;
            r_h_i   <= '0;
            r_b_r   <= '0;
            r_b_i   <= '0;
            r_row   <= '0;
            r_k     <= '0;
            r_col   <= '0;
            r_acc_r <= '0;
            r_acc_i <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
            for (int c = 0; c < NC; c++) begin
                for (int r = 0; r < NR; r++) begin
                    r_y_r[c][r] <= '0;
                    r_y_i[c][r] <= '0;
                end
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_h_r   <= h_r;
                        r_h_i   <= h_i;
                        r_b_r   <= b_r;
                        r_b_i   <= b_i;
                        r_ovf   <= 1'b0;
                        r_acc_r <= '0;
                        r_acc_i <= '0;
                        r_row   <= '0;
                        r_k     <= '0;
                        r_col   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (r_k == KW'(K-1)) begin
                        r_y_r[r_col][r_row] <= w_res_r;
                        r_y_i[r_col][r_row] <= w_res_i;
                        r_ovf   <= r_ovf | w_oor_r | w_oor_i;
                        r_acc_r <= '0;
                        r_acc_i <= '0;
                        r_k     <= '0;
                        if (r_row == RW'(NR-1)) begin
                            r_row <= '0;
                            if (r_col == CW'(NC-1)) begin
                                r_col   <= '0;
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_col <= r_col + CW'(1);
                            end
                        end else begin
                            r_row <= r_row + RW'(1);
                        end
                    end else begin
                        r_acc_r <= w_mac_r;
                        r_acc_i <= w_mac_i;
                        r_k     <= r_k + KW'(1);
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hqb_matmul_cal.sv
// Bench for hqb_matmul_cal: saturating and wrapping instances share stimulus.
// An element-level model predicts every output each cycle; directed tests pin known values.
// Inputs are driven 1 time unit after the rising edge, outputs compared on the falling edge.
module tb_hqb_matmul_cal;

    localparam int W = 16, FRAC = 8, NR = 4, K = 2, NC = 2;
    localparam int HW = NR*K*W, BW = K*NC*W, YW = NR*NC*W, NE = NR*NC, L = NR*NC*K;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [HW-1:0] h_r = '0, h_i = '0;
    logic [BW-1:0] b_r = '0, b_i = '0;
    logic [YW-1:0] y_r_s, y_i_s, y_r_w, y_i_w;
    logic busy_s, done_s, ovf_s, busy_w, done_w, ovf_w;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    hqb_matmul_cal #(.W(W), .FRAC(FRAC), .NR(NR), .K(K), .NC(NC), .SAT(1)) dut_s (
        .clk(clk), .rst(rst), .start(start), .h_r(h_r), .h_i(h_i), .b_r(b_r), .b_i(b_i),
        .y_r(y_r_s), .y_i(y_i_s), .busy(busy_s), .done(done_s), .ovf(ovf_s));

    hqb_matmul_cal #(.W(W), .FRAC(FRAC), .NR(NR), .K(K), .NC(NC), .SAT(0)) dut_w (
        .clk(clk), .rst(rst), .start(start), .h_r(h_r), .h_i(h_i), .b_r(b_r), .b_i(b_i),
        .y_r(y_r_w), .y_i(y_i_w), .busy(busy_w), .done(done_w), .ovf(ovf_w));

    task automatic check(input string nm, input logic [YW-1:0] act, input logic [YW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic longint elem_sh(input logic [HW-1:0] hr, input logic [HW-1:0] hi,
                                       input logic [BW-1:0] br, input logic [BW-1:0] bi,
                                       input int r, input int c, input bit im);
        longint acc = 0;
        for (int k = 0; k < K; k++) begin
            logic signed [W-1:0] t;
            longint ar, ai, xr, xi;
            t = hr[(r*K+k)*W +: W]; ar = t;
            t = hi[(r*K+k)*W +: W]; ai = t;
            t = br[(k*NC+c)*W +: W]; xr = t;
            t = bi[(k*NC+c)*W +: W]; xi = t;
            acc += im ? (ar*xi + ai*xr) : (ar*xr - ai*xi);
        end
        return acc >>> FRAC;
    endfunction

    function automatic bit oor(input longint v);
        longint lim = longint'(1) << (W-1);
        return (v > lim - 1) || (v < -lim);
    endfunction

    function automatic logic [W-1:0] red(input longint v, input bit sat);
        longint lim = longint'(1) << (W-1);
        if (sat && v > lim - 1) return {1'b0, {(W-1){1'b1}}};
        if (sat && v < -lim)    return {1'b1, {(W-1){1'b0}}};
        return v[W-1:0];
    endfunction

    // index s: 0 = saturating instance, 1 = wrapping instance; element e = c*NR + r
    bit            m_run;
    int            m_cnt;
    logic [W-1:0]  m_new_r [2][NE], m_new_i [2][NE], m_cur_r [2][NE], m_cur_i [2][NE];
    bit            m_new_ovf [NE];
    bit            m_ovf [2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run <= 1'b0;
            m_cnt <= 0;
            for (int s = 0; s < 2; s++) begin
                m_ovf[s] <= 1'b0;
                for (int e = 0; e < NE; e++) begin
                    m_cur_r[s][e] <= '0;
                    m_cur_i[s][e] <= '0;
                end
            end
        end else if (m_run) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == L + 1) m_run <= 1'b0;
            for (int e = 0; e < NE; e++) begin
                if ((e + 1) * K == m_cnt + 1) begin
                    for (int s = 0; s < 2; s++) begin
                        m_cur_r[s][e] <= m_new_r[s][e];
                        m_cur_i[s][e] <= m_new_i[s][e];
                        if (m_new_ovf[e]) m_ovf[s] <= 1'b1;
                    end
                end
            end
        end else if (start) begin
            m_run <= 1'b1;
            m_cnt <= 0;
            for (int e = 0; e < NE; e++) begin
                longint vr, vi;
                vr = elem_sh(h_r, h_i, b_r, b_i, e % NR, e / NR, 1'b0);
                vi = elem_sh(h_r, h_i, b_r, b_i, e % NR, e / NR, 1'b1);
                m_new_ovf[e] <= oor(vr) || oor(vi);
                for (int s = 0; s < 2; s++) begin
                    m_ovf[s] <= 1'b0;
                    m_new_r[s][e] <= red(vr, s == 0);
                    m_new_i[s][e] <= red(vi, s == 0);
                end
            end
        end
    end

    // compare both instances against the model every cycle
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int s = 0; s < 2; s++) begin
                logic [YW-1:0] er, ei;
                er = '0;
                ei = '0;
                for (int e = 0; e < NE; e++) begin
                    er[e*W +: W] = m_cur_r[s][e];
                    ei[e*W +: W] = m_cur_i[s][e];
                end
                check($sformatf("s%0d busy", s), YW'(s == 0 ? busy_s : busy_w), YW'(m_run));
                check($sformatf("s%0d done", s), YW'(s == 0 ? done_s : done_w),
                      YW'(m_run && m_cnt == L));
                check($sformatf("s%0d ovf", s), YW'(s == 0 ? ovf_s : ovf_w), YW'(m_ovf[s]));
                check($sformatf("s%0d y_r", s), s == 0 ? y_r_s : y_r_w, er);
                check($sformatf("s%0d y_i", s), s == 0 ? y_i_s : y_i_w, ei);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_identity_b();
        b_r = '0;
        b_i = '0;
        for (int k = 0; k < K; k++)
            for (int c = 0; c < NC; c++)
                if (k == c) b_r[(k*NC+c)*W +: W] = 16'h0100;
    endtask

    task automatic rand_h();
        for (int e = 0; e < NR*K; e++) begin
            h_r[e*W +: W] = W'($urandom_range(0, 65535));
            h_i[e*W +: W] = W'($urandom_range(0, 65535));
        end
    endtask

    // pulse start, return the edge index (accept = 0) at which done is first seen
    task automatic run_and_wait(output int lat);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40 && lat < 0; i++) begin
            @(posedge clk); #1;
            if (done_s) lat = i;
        end
        @(posedge clk); #1;
    endtask

    // identity check: y(r,c) must equal h(r,c) captured in hr0/hi0
    task automatic check_identity(input string nm, input logic [HW-1:0] hr0,
                                  input logic [HW-1:0] hi0);
        for (int r = 0; r < NR; r++) begin
            for (int c = 0; c < NC; c++) begin
                check($sformatf("%s y_r(%0d,%0d)", nm, r, c),
                      YW'(y_r_s[(c*NR+r)*W +: W]), YW'(hr0[(r*K+c)*W +: W]));
                check($sformatf("%s y_i(%0d,%0d)", nm, r, c),
                      YW'(y_i_s[(c*NR+r)*W +: W]), YW'(hi0[(r*K+c)*W +: W]));
            end
        end
    endtask

    initial begin
        int lat, nd;
        logic [HW-1:0] hr0, hi0;
        logic [YW-1:0] ev;

        repeat (2) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        check("reset y_r", y_r_s, '0);
        check("reset busy", YW'(busy_s), '0);
        rst = 1'b0;
        @(posedge clk); #1;

        // identity B, random H
        rand_h();
        set_identity_b();
        hr0 = h_r; hi0 = h_i;
        run_and_wait(lat);
        check("identity latency", YW'(lat), YW'(L));
        check_identity("ident", hr0, hi0);
        check("identity ovf", YW'(ovf_s), '0);

        // (1+j)*(1+j) = 2j in element (0,0)
        h_r = '0; h_i = '0; b_r = '0; b_i = '0;
        h_r[W-1:0] = 16'h0100; h_i[W-1:0] = 16'h0100;
        b_r[W-1:0] = 16'h0100; b_i[W-1:0] = 16'h0100;
        run_and_wait(lat);
        ev = '0;
        ev[W-1:0] = 16'h0200;
        check("cplx y_r", y_r_s, '0);
        check("cplx y_i", y_i_s, ev);

        // saturation vs wrap
        h_i = '0; b_i = '0;
        for (int e = 0; e < NR*K; e++) h_r[e*W +: W] = 16'h7FFF;
        for (int e = 0; e < K*NC; e++) b_r[e*W +: W] = 16'h0200;
        run_and_wait(lat);
        for (int e = 0; e < NE; e++) begin
            check($sformatf("sat y_r[%0d]", e), YW'(y_r_s[e*W +: W]), YW'(16'h7FFF));
            check($sformatf("wrap y_r[%0d]", e), YW'(y_r_w[e*W +: W]), YW'(16'hFFFC));
        end
        check("sat ovf", YW'(ovf_s), YW'(1));
        check("wrap ovf", YW'(ovf_w), YW'(1));

        // negative truncation toward minus infinity
        h_r = '0; b_r = '0;
        h_r[W-1:0] = 16'hFFFF;
        b_r[W-1:0] = 16'h0080;
        run_and_wait(lat);
        ev = '0;
        ev[W-1:0] = 16'hFFFF;
        check("negtrunc y_r", y_r_s, ev);
        check("negtrunc ovf", YW'(ovf_s), '0);

        // start while busy ignored, inputs changed mid-run
        rand_h();
        set_identity_b();
        hr0 = h_r; hi0 = h_i;
        nd = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (done_s) nd++;
            if (i == 2) start = 1'b1;
            if (i == 3) begin
                start = 1'b0;
                rand_h();
                b_r = ~b_r;
            end
            if (i == 16) start = 1'b1;
            if (i == 17) start = 1'b0;
        end
        check("handshake done count", YW'(nd), YW'(1));
        check("handshake idle", YW'(busy_s), '0);
        check_identity("hs", hr0, hi0);

        // reset in the middle of a run
        rand_h();
        set_identity_b();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst busy", YW'(busy_s), '0);
        check("midrst done", YW'(done_s), '0);
        check("midrst ovf", YW'(ovf_s), '0);
        check("midrst y_r", y_r_s, '0);
        check("midrst y_i", y_i_s, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rand_h();
        hr0 = h_r; hi0 = h_i;
        run_and_wait(lat);
        check("post-reset latency", YW'(lat), YW'(L));
        check_identity("postrst", hr0, hi0);

        // start held high: a new run on every return to IDLE
        nd = 0;
        start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done_s) nd++;
        end
        start = 1'b0;
        check("held start done count", YW'(nd), YW'(2));
        repeat (20) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hqb_matmul_cal.md
HQB_MATMUL_CAL -- requirements
Module: hqb_matmul_cal

Interface
REQ-001 The block SHALL take parameter W, default 16, the signed two's-complement element width.
REQ-002 The block SHALL take parameter FRAC, default 8, the number of fractional bits (Q(W-FRAC).FRAC).
REQ-003 The block SHALL take parameter NR, default 4, the number of rows of H and of Y.
REQ-004 The block SHALL take parameter K, default 2, the number of columns of H and rows of B.
REQ-005 The block SHALL take parameter NC, default 2, the number of columns of B and of Y.
REQ-006 The block SHALL take parameter SAT, default 1: 1 = saturate results, 0 = wrap results.
REQ-007 clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-008 rst  in  1  reset, asynchronous and active-high.
REQ-009 start  in  1  request to compute; sampled only in IDLE.
REQ-010 h_r, h_i  in  NR*K*W each  real and imaginary parts of H; element (r,k) at bits [(r*K+k+1)*W-1 : (r*K+k)*W].
REQ-011 b_r, b_i  in  K*NC*W each  real and imaginary parts of B; element (k,c) at index k*NC+c.
REQ-012 y_r, y_i  out  NR*NC*W each  real and imaginary parts of Y = H*B, column-major; element (r,c) at index c*NR+r.
REQ-013 busy  out  1  high in CALC and DONE.
REQ-014 done  out  1  one-cycle pulse; Y is valid from this cycle onward.
REQ-015 ovf  out  1  sticky flag; set if any element of the current run saturated (SAT=1) or wrapped (SAT=0).

Function
REQ-016 The FSM SHALL have exactly three states:
- IDLE -> CALC on a clock edge with start=1.
- CALC -> DONE on the edge completing the last MAC.
- DONE -> IDLE unconditionally on the next edge.
REQ-017 On the accepting edge the block SHALL:
- capture h_r/h_i/b_r/b_i into internal registers, so later input changes do not affect the run;
- clear ovf;
- zero the accumulator and the indices r, c, k.
REQ-018 Each CALC cycle SHALL perform one complex MAC: acc_r += h_r(r,k)*b_r(k,c) - h_i(r,k)*b_i(k,c); acc_i += h_r(r,k)*b_i(k,c) + h_i(r,k)*b_r(k,c).
REQ-019 Products SHALL be full 2W-bit signed; the accumulator SHALL be 2W+1+clog2(K) bits wide, so it never overflows internally.
REQ-020 Index order SHALL be k innermost, then r, then c; k, r and c each wrap to 0 at K, NR and NC respectively.
REQ-021 When k=K-1, the same edge SHALL:
- write element (r,c) of y_r/y_i;
- reset the accumulator to 0.
REQ-022 The result written SHALL be acc >>> FRAC (arithmetic shift, truncation toward minus infinity), then reduced to W bits:
- SAT=1: clamp to [-2^(W-1), 2^(W-1)-1];
- SAT=0: keep the low W bits.
REQ-023 ovf SHALL be set on any write where the shifted value lies outside the signed W-bit range.
REQ-024 Latency: with the accepting edge numbered 0, the last write SHALL occur at edge NR*NC*K, and done SHALL be high for exactly the following cycle (default: done high after edge 16, for one cycle).
REQ-025 start while busy=1 (CALC or DONE) SHALL be ignored; start held high continuously SHALL start a new run on each return to IDLE.
REQ-026 y_r, y_i and ovf SHALL hold their values after DONE until the next accepted start.
REQ-027 Before the last write, y elements SHALL show the values of the previous run; already-written elements SHALL show new values.
REQ-028 Parameters SHALL satisfy NR, NC, K >= 1 and FRAC < W; behaviour is undefined otherwise.

Reset
REQ-029 rst=1 SHALL immediately force: state=IDLE; busy=0, done=0, ovf=0; y_r=0, y_i=0; accumulator, indices and operand registers = 0.
REQ-030 Reset asserted mid-CALC SHALL abort the run with no done pulse; the first start after rst deasserts SHALL begin a complete fresh run.

Verification (defaults W=16, FRAC=8, NR=4, K=2, NC=2, SAT=1)
REQ-031 Identity: b_r = I (0x0100 on the diagonal), b_i=0, random H -> y(r,c) = h(r,c) for c<2, done exactly 17 cycles after start is sampled, ovf=0.
REQ-032 Complex product: h(0,0)=0x0100+j0x0100, b(0,0)=0x0100+j0x0100, all other elements 0 -> y_r(0,0)=0x0000, y_i(0,0)=0x0200, all other outputs 0.
REQ-033 Saturation: all h_r=0x7FFF, all b_r=0x0200, imaginary parts 0 -> every y_r=0x7FFF, ovf=1; repeat with SAT=0 -> every y_r=0xFFFC, ovf=1.
REQ-034 Negative truncation: h_r(0,0)=0xFFFF, b_r(0,0)=0x0080, all others 0 -> y_r(0,0)=0xFFFF.
REQ-035 Handshake: start pulsed again at cycles 3 and 17 after the first accept -> both ignored, exactly one done pulse; changing inputs mid-run does not alter Y.
REQ-036 Reset mid-CALC at cycle 5 -> all outputs 0 immediately, no done pulse; a new start then yields the correct Y after 17 cycles.
